// File: rtl/clock_div_switch_m.sv
// Divided CPU clock generator with glitch-free mode switching.
// Mode changes land only on a rising edge of ck_op; hold stretches phi1.
module clock_div_switch_m #(
    parameter int MODE_BITS = 2,
    parameter int CNT_W = 4,
    parameter logic [(2**MODE_BITS)*CNT_W-1:0] HALF_PERIODS =
        {4'd8, 4'd4, 4'd2, 4'd1},
    parameter int RESET_MODE = 0
) (
    input  logic                 ck_ip,
    input  logic                 reset_ip,
    input  logic [MODE_BITS-1:0] sel_ip,
    input  logic                 req_ip,
    input  logic                 hold_ip,
    output logic                 ck_op,
    output logic                 rise_op,
    output logic                 fall_op,
    output logic [MODE_BITS-1:0] selected_op,
    output logic                 busy_op,
    output logic                 ack_op
);

    localparam int NUM_MODES = 2 ** MODE_BITS;
    localparam logic [MODE_BITS-1:0] RST_MODE = MODE_BITS'(RESET_MODE);

    typedef enum logic [1:0] {
        ST_HIGH = 2'd0,
        ST_HOLD = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ck_q, ck_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic [MODE_BITS-1:0] selected_q, selected_d;
    logic [MODE_BITS-1:0] pending_q, pending_d;
    logic                 busy_q, busy_d;
    logic                 ack_q, ack_d;

    logic [CNT_W-1:0]     h_raw;
    logic [CNT_W-1:0]     h_last;
    logic                 phase_end;
    logic                 switch_now;

    // Look up the half-period of the mode in force; zero behaves as one
    always_comb begin
        h_raw = '0;
        for (int k = 0; k < NUM_MODES; k++) begin
            if (selected_q == MODE_BITS'(k)) begin
                h_raw = HALF_PERIODS[k*CNT_W +: CNT_W];
            end
        end
        h_last    = (h_raw == '0) ? '0 : h_raw - CNT_W'(1);
        phase_end = (cnt_q == h_last);
    end

    // Phase state register and counter
    always_ff @(posedge ck_ip or posedge reset_ip) begin
        if (reset_ip) begin
            state_q <= ST_HIGH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next phase: count each half-period, park in HOLD while stretched
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
            ST_HIGH: begin
                if (phase_end) begin
                    cnt_d   = '0;
                    state_d = hold_ip ? ST_HOLD : ST_LOW;
                end
            end
            ST_HOLD: begin
                cnt_d = '0;
                if (!hold_ip) begin
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (phase_end) begin
                    cnt_d   = '0;
                    state_d = ST_HIGH;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_HIGH;
            end
        endcase
    end

    // Clock level and edge markers derived from the coming phase
    always_comb begin
        ck_d   = (state_d != ST_LOW);
        rise_d = (state_q == ST_LOW) && (state_d == ST_HIGH);
        fall_d = (state_q != ST_LOW) && (state_d == ST_LOW);
    end

    // Registered clock outputs so nothing combinational reaches a pin
    always_ff @(posedge ck_ip or posedge reset_ip) begin
        if (reset_ip) begin
            ck_q   <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            ck_q   <= ck_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    // Accept one request at a time; apply it on the next rising edge
    always_comb begin
        selected_d = selected_q;
        pending_d  = pending_q;
        busy_d     = busy_q;
        switch_now = rise_d && busy_q;
        ack_d      = switch_now;
        if (switch_now) begin
            selected_d = pending_q;
            busy_d     = 1'b0;
        end else if (req_ip && !busy_q) begin
            pending_d = sel_ip;
            busy_d    = 1'b1;
        end
    end

    // Mode and handshake registers
    always_ff @(posedge ck_ip or posedge reset_ip) begin
        if (reset_ip) begin
            selected_q <= RST_MODE;
            pending_q  <= '0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            selected_q <= selected_d;
            pending_q  <= pending_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
        end
    end

    assign ck_op       = ck_q;
    assign rise_op     = rise_q;
    assign fall_op     = fall_q;
    assign selected_op = selected_q;
    assign busy_op     = busy_q;
    assign ack_op      = ack_q;

endmodule

// File: tb/tb_clock_div_switch_m.sv
// Bench for clock_div_switch_m: default instance plus one with a zero
// half-period field, both checked every cycle against a phase model.
module tb_clock_div_switch_m;

    logic       ck_ip    = 1'b0;
    logic       reset_ip = 1'b1;
    logic       req_ip   = 1'b0;
    logic       hold_ip  = 1'b0;
    logic [1:0] sel_ip   = 2'd0;

    logic       ck_o   [2];
    logic       rise_o [2];
    logic       fall_o [2];
    logic       busy_o [2];
    logic       ack_o  [2];
    logic [1:0] sel_o  [2];

    int  total = 0;
    int  bad   = 0;
    bit  chk_en = 1'b0;

    always #5 ck_ip = ~ck_ip;

    clock_div_switch_m u_dut0 (
        .ck_ip(ck_ip), .reset_ip(reset_ip), .sel_ip(sel_ip),
        .req_ip(req_ip), .hold_ip(hold_ip),
        .ck_op(ck_o[0]), .rise_op(rise_o[0]), .fall_op(fall_o[0]),
        .selected_op(sel_o[0]), .busy_op(busy_o[0]), .ack_op(ack_o[0])
    );

    clock_div_switch_m #(
        .HALF_PERIODS({4'd0, 4'd4, 4'd2, 4'd1})
    ) u_dut1 (
        .ck_ip(ck_ip), .reset_ip(reset_ip), .sel_ip(sel_ip),
        .req_ip(req_ip), .hold_ip(hold_ip),
        .ck_op(ck_o[1]), .rise_op(rise_o[1]), .fall_op(fall_o[1]),
        .selected_op(sel_o[1]), .busy_op(busy_o[1]), .ack_op(ack_o[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a phase is just a level plus elapsed cycles.
    int hp [2][4];
    int m_hi [2], m_el [2], m_sel [2], m_pend [2], m_busy [2];
    int m_rise [2], m_fall [2], m_ack [2];
    int mh;

    initial begin
        hp[0] = '{1, 2, 4, 8};
        hp[1] = '{1, 2, 4, 0};
    end

    always @(posedge ck_ip or posedge reset_ip) begin
        for (int i = 0; i < 2; i++) begin
            if (reset_ip) begin
                m_hi[i] = 1; m_el[i] = 0; m_sel[i] = 0;
                m_pend[i] = 0; m_busy[i] = 0;
                m_rise[i] = 0; m_fall[i] = 0; m_ack[i] = 0;
            end else begin
                mh = hp[i][m_sel[i]];
                if (mh == 0) mh = 1;
                m_rise[i] = 0;
                m_fall[i] = 0;
                if (m_hi[i] == 1) begin
                    if (m_el[i] >= mh - 1 && !hold_ip) begin
                        m_hi[i] = 0; m_el[i] = 0; m_fall[i] = 1;
                    end else begin
                        m_el[i]++;
                    end
                end else begin
                    if (m_el[i] >= mh - 1) begin
                        m_hi[i] = 1; m_el[i] = 0; m_rise[i] = 1;
                    end else begin
                        m_el[i]++;
                    end
                end
                m_ack[i] = (m_rise[i] == 1 && m_busy[i] == 1) ? 1 : 0;
                if (m_ack[i] == 1) begin
                    m_sel[i]  = m_pend[i];
                    m_busy[i] = 0;
                end else if (req_ip && m_busy[i] == 0) begin
                    m_pend[i] = int'(sel_ip);
                    m_busy[i] = 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge ck_ip) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("ck%0d", i), int'(ck_o[i]), m_hi[i]);
                chk($sformatf("rise%0d", i), int'(rise_o[i]), m_rise[i]);
                chk($sformatf("fall%0d", i), int'(fall_o[i]), m_fall[i]);
                chk($sformatf("sel%0d", i), int'(sel_o[i]), m_sel[i]);
                chk($sformatf("busy%0d", i), int'(busy_o[i]), m_busy[i]);
                chk($sformatf("ack%0d", i), int'(ack_o[i]), m_ack[i]);
            end
        end
    end

    // Wait (bounded) for ack (which=0) or rise (which=1) on instance i
    task automatic wait_sig(input int which, input int i, input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge ck_ip);
            if ((which == 0 && ack_o[i]) || (which == 1 && rise_o[i])) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s timeout act=none exp=event", nm);
        end
    endtask

    // From a high sample, count high then low samples
    task automatic measure(input int i, output int hi, output int lo);
        hi = 0;
        lo = 0;
        for (int k = 0; k < 100 && ck_o[i]; k++) begin
            hi++;
            @(negedge ck_ip);
        end
        for (int k = 0; k < 100 && !ck_o[i]; k++) begin
            lo++;
            @(negedge ck_ip);
        end
    endtask

    int exp_ck [4];
    int exp_rs [4];
    int hi, lo, acks, falls;

    initial begin
        exp_ck = '{1, 0, 1, 0};
        exp_rs = '{0, 0, 1, 0};
        repeat (3) @(negedge ck_ip);
        @(posedge ck_ip);
        #1 reset_ip = 1'b0;
        chk_en = 1'b1;

        // Reset to mode 0: ck_ip/2 with rise at cycle 2
        for (int k = 0; k < 4; k++) begin
            @(negedge ck_ip);
            chk("rst_ck", int'(ck_o[0]), exp_ck[k]);
            chk("rst_rise", int'(rise_o[0]), exp_rs[k]);
        end
        chk("rst_sel", int'(sel_o[0]), 0);

        // Switch 0 -> 2
        #1 req_ip = 1'b1; sel_ip = 2'd2;
        @(negedge ck_ip);
        #1 req_ip = 1'b0;
        wait_sig(0, 0, "ack_sw2");
        chk("sw2_rise_with_ack", int'(rise_o[0]), 1);
        chk("sw2_sel", int'(sel_o[0]), 2);
        measure(0, hi, lo);
        chk("sw2_hi", hi, 4);
        chk("sw2_lo", lo, 4);

        // Switch to mode 3; instance 1 has a zero field there
        #1 req_ip = 1'b1; sel_ip = 2'd3;
        @(negedge ck_ip);
        #1 req_ip = 1'b0;
        wait_sig(0, 0, "ack_sw3");
        measure(0, hi, lo);
        chk("sw3_hi", hi, 8);
        chk("sw3_lo", lo, 8);
        wait_sig(1, 1, "rise_z");
        measure(1, hi, lo);
        chk("zero_hi", hi, 1);
        chk("zero_lo", lo, 1);

        // Second request while busy is dropped
        wait_sig(1, 0, "rise_busy");
        #1 req_ip = 1'b1; sel_ip = 2'd1;
        @(negedge ck_ip);
        #1 req_ip = 1'b0;
        repeat (2) @(negedge ck_ip);
        #1 req_ip = 1'b1; sel_ip = 2'd0;
        @(negedge ck_ip);
        #1 req_ip = 1'b0;
        acks = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge ck_ip);
            acks += int'(ack_o[0]);
        end
        chk("busy_acks", acks, 1);
        chk("busy_sel", int'(sel_o[0]), 1);

        // Hold stretch in mode 1: five hold samples from phase start
        wait_sig(1, 0, "rise_hold");
        #1 hold_ip = 1'b1;
        hi = 1;
        falls = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge ck_ip);
            falls += int'(fall_o[0]);
            if (k == 4) #1 hold_ip = 1'b0;
            if (ck_o[0]) hi++;
            else break;
        end
        hold_ip = 1'b0;
        lo = 0;
        for (int k = 0; k < 40 && !ck_o[0]; k++) begin
            lo++;
            @(negedge ck_ip);
        end
        chk("hold_hi", hi, 6);
        chk("hold_lo", lo, 2);
        chk("hold_falls", falls, 1);

        // Reset in mid-switch
        #1 req_ip = 1'b1; sel_ip = 2'd3;
        @(negedge ck_ip);
        chk("mid_busy", int'(busy_o[0]), 1);
        #1 req_ip = 1'b0; reset_ip = 1'b1;
        #1;
        chk("mid_ck", int'(ck_o[0]), 1);
        chk("mid_busy0", int'(busy_o[0]), 0);
        chk("mid_ack", int'(ack_o[0]), 0);
        chk("mid_sel", int'(sel_o[0]), 0);
        chk("mid_rise", int'(rise_o[0]), 0);
        chk("mid_fall", int'(fall_o[0]), 0);
        @(posedge ck_ip);
        #1 reset_ip = 1'b0;

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            @(negedge ck_ip);
            #1;
            req_ip = ($urandom % 6) == 0;
            sel_ip = 2'($urandom);
            if (($urandom % 8) == 0) hold_ip = ~hold_ip;
            if (reset_ip) reset_ip = 1'b0;
            else if (($urandom % 700) == 0) reset_ip = 1'b1;
        end
        reset_ip = 1'b0;
        hold_ip  = 1'b0;
        req_ip   = 1'b0;
        @(negedge ck_ip);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
